// File: rtl/alu_nbit_seq.sv
// Sequential N-bit ALU with an iterative shift-add multiplier.
//
// Operands and opcode are captured on the edge where start is seen in idle.
// Single-cycle ops spend one cycle in StExec. MUL spends WIDTH+1 cycles in
// StMul: WIDTH shift-add iterations and then one commit cycle. Both paths
// finish with a one-cycle StDone. The result and flag registers only change
// on the edge that enters StDone, so they hold steady while an op runs.
//
// Ports:
//   clk       system clock, rising edge
//   rst       synchronous active-high reset; aborts any op in flight
//   start     begin an operation (ignored while busy)
//   op        3-bit opcode: AND, OR, ADD, SUB, SLT, NOR, MUL, reserved
//   a, b      WIDTH-bit operands
//   busy      high while an operation is in progress (StExec/StMul/StDone)
//   done      one-cycle pulse when result and flags are valid
//   result    low word of the registered result
//   hi        high word of the MUL product, 0 for other ops
//   c_out     carry out of the MSB (ADD/SUB only)
//   overflow  signed overflow (ADD/SUB only)
//   zero      result (or full product for MUL) is zero
module alu_nbit_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             c_out,
    output logic             overflow,
    output logic             zero
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    localparam logic [2:0] OpAnd = 3'b000;
    localparam logic [2:0] OpOr  = 3'b001;
    localparam logic [2:0] OpAdd = 3'b010;
    localparam logic [2:0] OpSub = 3'b011;
    localparam logic [2:0] OpSlt = 3'b100;
    localparam logic [2:0] OpNor = 3'b101;
    localparam logic [2:0] OpMul = 3'b110;

    typedef enum logic [1:0] {StIdle, StExec, StMul, StDone} state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CntW-1:0]    cnt_q;
    logic [WIDTH-1:0]   result_q, hi_q;
    logic               c_out_q, overflow_q, zero_q;

    // Shared adder: SUB and SLT both use a + ~b + 1.
    logic               sub_sel;
    logic [WIDTH-1:0]   b_eff;
    logic [WIDTH:0]     sum_full;
    logic [WIDTH-1:0]   sum_low;
    logic               carry_msb_in, carry_msb_out, add_ovf;

    assign sub_sel       = (op_q == OpSub) || (op_q == OpSlt);
    assign b_eff         = sub_sel ? ~b_q : b_q;
    assign sum_full      = {1'b0, a_q} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub_sel};
    // Sum of the low WIDTH-1 bits; its top bit is the carry into the MSB.
    assign sum_low       = {1'b0, a_q[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
                         + {{(WIDTH-1){1'b0}}, sub_sel};
    assign carry_msb_in  = sum_low[WIDTH-1];
    assign carry_msb_out = sum_full[WIDTH];
    assign add_ovf       = carry_msb_in ^ carry_msb_out;

    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            OpAnd: alu_res = a_q & b_q;
            OpOr:  alu_res = a_q | b_q;
            OpAdd, OpSub: begin
                alu_res = sum_full[WIDTH-1:0];
                alu_c   = carry_msb_out;
                alu_v   = add_ovf;
            end
            OpSlt: alu_res = {{(WIDTH-1){1'b0}}, sum_full[WIDTH-1] ^ add_ovf};
            OpNor: alu_res = ~(a_q | b_q);
            default: alu_res = '0;
        endcase
    end

    // One shift-add step: acc holds {partial high, remaining multiplier bits}.
    logic [WIDTH:0]     mul_add;
    logic [2*WIDTH-1:0] acc_step;

    assign mul_add  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    assign acc_step = {mul_add, acc_q[WIDTH-1:1]};

    logic mul_last;
    assign mul_last = (cnt_q == CntW'(WIDTH));

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (start) state_d = (op == OpMul) ? StMul : StExec;
            StExec: state_d = StDone;
            StMul:  if (mul_last) state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            result_q   <= '0;
            hi_q       <= '0;
            c_out_q    <= 1'b0;
            overflow_q <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        acc_q <= {{WIDTH{1'b0}}, b};
                        cnt_q <= '0;
                    end
                end
                StExec: begin
                    result_q   <= alu_res;
                    hi_q       <= '0;
                    c_out_q    <= alu_c;
                    overflow_q <= alu_v;
                    zero_q     <= (alu_res == '0);
                end
                StMul: begin
                    if (mul_last) begin
                        // Commit cycle: all WIDTH iterations are already in acc.
                        result_q   <= acc_q[WIDTH-1:0];
                        hi_q       <= acc_q[2*WIDTH-1:WIDTH];
                        c_out_q    <= 1'b0;
                        overflow_q <= 1'b0;
                        zero_q     <= (acc_q == '0);
                        cnt_q      <= '0;
                    end else begin
                        acc_q <= acc_step;
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign result   = result_q;
    assign hi       = hi_q;
    assign c_out    = c_out_q;
    assign overflow = overflow_q;
    assign zero     = zero_q;

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Scoreboard bench for alu_nbit_seq (WIDTH=8): the stimulus process pushes
// the expected response of each accepted op; a monitor pops and compares on
// every done pulse and otherwise checks that the outputs hold.
module tb_alu_nbit_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [2:0]   op = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, c_out, overflow, zero;
    logic [W-1:0] result, hi;

    alu_nbit_seq #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .hi       (hi),
        .c_out    (c_out),
        .overflow (overflow),
        .zero     (zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    typedef struct {
        longint r;
        longint h;
        bit     c;
        bit     v;
        bit     z;
        int     lat;
        int     issue;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference model straight from the operation definitions.
    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x,
                                   input logic [W-1:0] y);
        exp_t   e;
        longint m, ux, uy, sx, sy, full, p;
        m  = longint'(1) << W;
        ux = longint'(x);
        uy = longint'(y);
        sx = (ux >= m / 2) ? ux - m : ux;
        sy = (uy >= m / 2) ? uy - m : uy;
        e.r = 0; e.h = 0; e.c = 0; e.v = 0; e.lat = 2; e.issue = 0;
        case (o)
            3'd0: e.r = ux & uy;
            3'd1: e.r = ux | uy;
            3'd2: begin
                full = ux + uy;
                e.r  = full % m;
                e.c  = (full >= m);
                e.v  = (sx + sy > m / 2 - 1) || (sx + sy < -(m / 2));
            end
            3'd3: begin
                full = ux + (m - 1 - uy) + 1;
                e.r  = full % m;
                e.c  = (full >= m);
                e.v  = (sx - sy > m / 2 - 1) || (sx - sy < -(m / 2));
            end
            3'd4: e.r = (sx < sy) ? 1 : 0;
            3'd5: e.r = (m - 1) & ~(ux | uy);
            3'd6: begin
                p     = ux * uy;
                e.r   = p % m;
                e.h   = p / m;
                e.lat = W + 2;
            end
            default: e.r = 0;
        endcase
        e.z = (e.r == 0) && (e.h == 0);
        return e;
    endfunction

    // Monitor: reset flushes the scoreboard; done pops and compares.
    initial begin
        logic           rs;
        exp_t           e;
        logic [2*W+2:0] snap;
        logic [2*W+2:0] now_v;
        snap = '0;
        forever begin
            @(posedge clk);
            rs = rst;
            @(negedge clk);
            now_v = {hi, result, c_out, overflow, zero};
            if (rs) begin
                exp_q.delete();
                snap = '0;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("result", longint'(result), e.r);
                    chk("hi", longint'(hi), e.h);
                    chk("c_out", longint'(c_out), longint'(e.c));
                    chk("overflow", longint'(overflow), longint'(e.v));
                    chk("zero", longint'(zero), longint'(e.z));
                    chk("latency", longint'(cyc - e.issue), longint'(e.lat));
                end
                snap = now_v;
            end else begin
                chk("outputs hold", longint'(now_v), longint'(snap));
            end
        end
    end

    // Wait at negedges until idle; optionally throw ignored starts meanwhile.
    task automatic wait_idle(input bit junk);
        int n = 0;
        while (busy && n < 200) begin
            if (junk && $urandom_range(0, 3) == 0) begin
                start = 1'b1;
                op    = 3'($urandom);
                a     = W'($urandom);
                b     = W'($urandom);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        if (n >= 200) chk("idle timeout", 1, 0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x,
                         input logic [W-1:0] y, input bit junk);
        exp_t e;
        wait_idle(junk);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        e       = model(o, x, y);
        e.issue = cyc;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        // Inputs wander after capture; the op in flight must not see them.
        op    = 3'($urandom);
        a     = W'($urandom);
        b     = W'($urandom);
    endtask

    function automatic logic [W-1:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset busy", longint'(busy), 0);
        chk("reset done", longint'(done), 0);
        chk("reset result", longint'(result), 0);
        chk("reset hi", longint'(hi), 0);
        chk("reset c_out", longint'(c_out), 0);
        chk("reset overflow", longint'(overflow), 0);
        chk("reset zero", longint'(zero), 0);
        rst = 1'b0;
        @(negedge clk);

        issue(3'b010, 8'h7F, 8'h01, 1'b0);
        issue(3'b011, 8'h05, 8'h05, 1'b0);
        issue(3'b100, 8'hFF, 8'h01, 1'b0);
        wait_idle(1'b0);
        chk("slt direct", longint'(result), 1);

        // MUL with an ignored start at cycle 4.
        issue(3'b110, 8'hFF, 8'hFF, 1'b0);
        repeat (3) @(negedge clk);
        chk("busy during mul", longint'(busy), 1);
        start = 1'b1;
        op    = 3'b010;
        a     = 8'h01;
        b     = 8'h01;
        @(negedge clk);
        start = 1'b0;
        wait_idle(1'b0);
        chk("mul lo direct", longint'(result), 'h01);
        chk("mul hi direct", longint'(hi), 'hFE);

        // MUL aborted by reset at cycle 5.
        issue(3'b110, 8'h0C, 8'h0A, 1'b0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", longint'(busy), 0);
        chk("abort done", longint'(done), 0);
        chk("abort outputs", longint'({hi, result, c_out, overflow, zero}), 0);
        repeat (12) @(negedge clk);
        issue(3'b010, 8'h01, 8'h01, 1'b0);
        wait_idle(1'b0);
        chk("add after abort", longint'(result), 2);

        issue(3'b111, 8'hAA, 8'h55, 1'b0);
        issue(3'b101, 8'hF0, 8'h0F, 1'b0);
        // Back-to-back: second start lands in the idle cycle after done.
        issue(3'b000, 8'hF0, 8'h3C, 1'b0);
        issue(3'b001, 8'hF0, 8'h0F, 1'b0);

        for (int i = 0; i < 80; i++) begin
            issue(3'($urandom), pick_operand(), pick_operand(), 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        wait_idle(1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard drained", longint'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
